// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer
//   Control unit for a single-cycle RV32I datapath. It decodes opcode/f3/
//   f7_bit6/zero into datapath controls and owns the datapath clock enable
//   through a HOLD/RUN/HALT/STEP sequencer.
//   - SYSTEM and illegal opcodes halt the core before they execute.
//   - A retired-instruction counter gives debug visibility.
// Ports
//   i_clk, i_rst                   clock, async active-high reset
//   i_opcode, i_f3, i_f7_bit6      instruction fields
//   i_zero                         ALU zero flag
//   i_run_en, i_step, i_resume     run level, step pulse, resume pulse
//   o_res_src, o_pc_src, o_alu_op, o_imm_ctl, o_alu_src_b   datapath controls
//   o_reg_wr, o_mem_wr             write enables, gated by o_clk_enable
//   o_clk_enable                   datapath state-update enable
//   o_halted, o_halt_cause         debug status
//   o_retired                      executed-instruction count
module ctrl_sequencer #(
   parameter int RESET_HOLD = 2,
   parameter int CNT_W      = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [6:0]       i_opcode,
   input  logic [2:0]       i_f3,
   input  logic             i_f7_bit6,
   input  logic             i_zero,
   input  logic             i_run_en,
   input  logic             i_step,
   input  logic             i_resume,
   output logic [1:0]       o_res_src,
   output logic [1:0]       o_pc_src,
   output logic [2:0]       o_alu_op,
   output logic [1:0]       o_imm_ctl,
   output logic             o_alu_src_b,
   output logic             o_reg_wr,
   output logic             o_mem_wr,
   output logic             o_clk_enable,
   output logic             o_halted,
   output logic [1:0]       o_halt_cause,
   output logic [CNT_W-1:0] o_retired
);
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [1:0] C_NONE = 2'b00, C_RUNEN = 2'b01, C_SYS = 2'b10, C_ILL = 2'b11;

   typedef enum logic [1:0] {S_HOLD, S_RUN, S_HALT, S_STEP} state_t;

   state_t           r_state, w_nxt_state;
   logic [3:0]       r_hold_cnt, w_nxt_hold;
   logic [1:0]       r_cause, w_nxt_cause;
   logic             r_skip, w_nxt_skip;
   logic [CNT_W-1:0] r_retired;

   logic [1:0] w_res, w_pc, w_imm;
   logic [2:0] w_alu;
   logic       w_srcb, w_rw, w_mw, w_legal, w_system, w_clk_en, w_nop;

   // Shared f3 -> ALU op map for R and I-ALU; f3=011 has no listed op and falls to ADD.
   function automatic logic [2:0] f3_alu(input logic [2:0] f3);
      case (f3)
         3'b111:  f3_alu = 3'b010;
         3'b110:  f3_alu = 3'b011;
         3'b010:  f3_alu = 3'b100;
         3'b100:  f3_alu = 3'b101;
         3'b001:  f3_alu = 3'b110;
         3'b101:  f3_alu = 3'b111;
         default: f3_alu = 3'b000;
      endcase
   endfunction

   // Decode
   always_comb begin
      w_res    = 2'b00;
      w_pc     = 2'b00;
      w_alu    = 3'b000;
      w_imm    = 2'b00;
      w_srcb   = 1'b0;
      w_rw     = 1'b0;
      w_mw     = 1'b0;
      w_legal  = 1'b1;
      w_system = 1'b0;
      case (i_opcode)
         OP_R: begin
            w_alu = (i_f3 == 3'b000 && i_f7_bit6) ? 3'b001 : f3_alu(i_f3);
            w_rw  = 1'b1;
         end
         OP_I: begin
            w_alu  = f3_alu(i_f3);
            w_srcb = 1'b1;
            w_rw   = 1'b1;
         end
         OP_LOAD: begin
            w_srcb = 1'b1;
            w_res  = 2'b01;
            w_rw   = 1'b1;
         end
         OP_STORE: begin
            w_imm  = 2'b01;
            w_srcb = 1'b1;
            w_mw   = 1'b1;
         end
         OP_BRANCH: begin
            w_alu = 3'b001;
            w_imm = 2'b10;
            if (i_f3 == 3'b000)      w_pc = i_zero  ? 2'b01 : 2'b00;
            else if (i_f3 == 3'b001) w_pc = !i_zero ? 2'b01 : 2'b00;
            else                     w_legal = 1'b0;
         end
         OP_JAL: begin
            w_imm = 2'b11;
            w_pc  = 2'b01;
            w_res = 2'b10;
            w_rw  = 1'b1;
         end
         OP_JALR: begin
            w_srcb = 1'b1;
            w_pc   = 2'b10;
            w_res  = 2'b10;
            w_rw   = 1'b1;
         end
         OP_SYSTEM: w_system = 1'b1;
         default:   w_legal  = 1'b0;
      endcase
   end

   // Sequencer next-state and clock enable
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_hold  = r_hold_cnt;
      w_nxt_cause = r_cause;
      w_nxt_skip  = r_skip;
      w_clk_en    = 1'b0;
      case (r_state)
         S_HOLD: begin
            if (r_hold_cnt <= 4'd1) begin
               w_nxt_state = i_run_en ? S_RUN : S_HALT;
               w_nxt_cause = i_run_en ? C_NONE : C_RUNEN;
            end else begin
               w_nxt_hold = r_hold_cnt - 4'd1;
            end
         end
         S_RUN: begin
            if (!i_run_en) begin
               w_nxt_state = S_HALT;
               w_nxt_cause = C_RUNEN;
            end else if (!w_legal) begin
               w_nxt_state = S_HALT;
               w_nxt_cause = C_ILL;
            end else if (w_system && !r_skip) begin
               w_nxt_state = S_HALT;
               w_nxt_cause = C_SYS;
               w_nxt_skip  = 1'b1;
            end else begin
               w_clk_en = 1'b1;
            end
         end
         S_HALT: begin
            if (i_resume && i_run_en && r_cause != C_ILL) begin
               w_nxt_state = S_RUN;
               w_nxt_cause = C_NONE;
            end else if (i_step && r_cause != C_ILL) begin
               w_nxt_state = S_STEP;
            end
         end
         default: begin // S_STEP: one instruction regardless of run_en
            w_nxt_state = S_HALT;
            if (!w_legal) begin
               w_nxt_cause = C_ILL;
            end else if (w_system && !r_skip) begin
               w_nxt_cause = C_SYS;
               w_nxt_skip  = 1'b1;
            end else begin
               w_clk_en = 1'b1;
            end
         end
      endcase
      // The skip flag is consumed by the first enabled cycle after it is set.
      if (w_clk_en) w_nxt_skip = 1'b0;
   end

   // Re-presented SYSTEM after a resume executes as a NOP.
   assign w_nop = r_skip & w_system;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_HOLD;
         r_hold_cnt <= 4'(RESET_HOLD);
         r_cause    <= C_NONE;
         r_skip     <= 1'b0;
         r_retired  <= '0;
      end else begin
         r_state    <= w_nxt_state;
         r_hold_cnt <= w_nxt_hold;
         r_cause    <= w_nxt_cause;
         r_skip     <= w_nxt_skip;
         if (w_clk_en && !w_nop) r_retired <= r_retired + 1'b1;
      end
   end

   assign o_res_src    = w_res;
   assign o_alu_op     = w_alu;
   assign o_imm_ctl    = w_imm;
   assign o_alu_src_b  = w_srcb;
   assign o_pc_src     = (w_clk_en && !w_nop) ? w_pc : 2'b00;
   assign o_reg_wr     = w_rw & w_clk_en & ~w_nop;
   assign o_mem_wr     = w_mw & w_clk_en & ~w_nop;
   assign o_clk_enable = w_clk_en;
   assign o_halted     = (r_state == S_HALT);
   assign o_halt_cause = r_cause;
   assign o_retired    = r_retired;
endmodule

// File: tb/tb_ctrl_sequencer.sv
module tb_ctrl_sequencer;
   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [6:0]  i_opcode;
   logic [2:0]  i_f3;
   logic        i_f7_bit6, i_zero, i_run_en, i_step, i_resume;
   logic [1:0]  o_res_src, o_pc_src, o_imm_ctl, o_halt_cause;
   logic [2:0]  o_alu_op;
   logic        o_alu_src_b, o_reg_wr, o_mem_wr, o_clk_enable, o_halted;
   logic [31:0] o_retired;

   int checks = 0;
   int failures = 0;
   int exp_ret = 0;

   ctrl_sequencer #(.RESET_HOLD(2), .CNT_W(32)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_f3(i_f3),
      .i_f7_bit6(i_f7_bit6), .i_zero(i_zero), .i_run_en(i_run_en),
      .i_step(i_step), .i_resume(i_resume), .o_res_src(o_res_src),
      .o_pc_src(o_pc_src), .o_alu_op(o_alu_op), .o_imm_ctl(o_imm_ctl),
      .o_alu_src_b(o_alu_src_b), .o_reg_wr(o_reg_wr), .o_mem_wr(o_mem_wr),
      .o_clk_enable(o_clk_enable), .o_halted(o_halted),
      .o_halt_cause(o_halt_cause), .o_retired(o_retired)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Apply one instruction in an enabled state and check every decode output.
   task automatic vec(input string tag, input logic [6:0] op, input logic [2:0] f3,
                      input logic f7, input logic z, input logic [1:0] rs,
                      input logic [1:0] pc, input logic [2:0] alu, input logic [1:0] imm,
                      input logic sb, input logic rw, input logic mw);
      i_opcode = op; i_f3 = f3; i_f7_bit6 = f7; i_zero = z;
      #1;
      chk({tag, ".en"},   32'(o_clk_enable), 32'd1);
      chk({tag, ".res"},  32'(o_res_src), 32'(rs));
      chk({tag, ".pc"},   32'(o_pc_src), 32'(pc));
      chk({tag, ".alu"},  32'(o_alu_op), 32'(alu));
      chk({tag, ".imm"},  32'(o_imm_ctl), 32'(imm));
      chk({tag, ".srcb"}, 32'(o_alu_src_b), 32'(sb));
      chk({tag, ".rw"},   32'(o_reg_wr), 32'(rw));
      chk({tag, ".mw"},   32'(o_mem_wr), 32'(mw));
   endtask

   initial begin
      i_rst = 1'b1; i_opcode = 7'b0010011; i_f3 = 3'b000; i_f7_bit6 = 1'b0;
      i_zero = 1'b0; i_run_en = 1'b1; i_step = 1'b0; i_resume = 1'b0;
      #3;
      chk("rst.en", 32'(o_clk_enable), 0);
      chk("rst.halted", 32'(o_halted), 0);
      chk("rst.cause", 32'(o_halt_cause), 0);
      chk("rst.retired", o_retired, 0);
      tick(); tick();
      i_rst = 1'b0;
      // Two HOLD cycles with the enable low, then free-run addi x1,x0,5.
      #1 chk("hold1.en", 32'(o_clk_enable), 0);
      chk("hold1.rw", 32'(o_reg_wr), 0);
      tick();
      chk("hold2.en", 32'(o_clk_enable), 0);
      tick();
      vec("addi0", 7'b0010011, 3'b000, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b1, 1'b0);
      chk("addi0.ret", o_retired, 0);
      tick(); exp_ret = 1;
      chk("addi1.ret", o_retired, 32'(exp_ret));
      tick(); exp_ret = 2;
      chk("addi2.ret", o_retired, 32'(exp_ret));

      // Decode table, one instruction per cycle, all retiring.
      vec("sub",  7'b0110011, 3'b000, 1'b1, 1'b0, 2'b00, 2'b00, 3'b001, 2'b00, 1'b0, 1'b1, 1'b0); tick(); exp_ret++;
      vec("and",  7'b0110011, 3'b111, 1'b0, 1'b0, 2'b00, 2'b00, 3'b010, 2'b00, 1'b0, 1'b1, 1'b0); tick(); exp_ret++;
      vec("srl",  7'b0110011, 3'b101, 1'b0, 1'b0, 2'b00, 2'b00, 3'b111, 2'b00, 1'b0, 1'b1, 1'b0); tick(); exp_ret++;
      vec("addf7",7'b0010011, 3'b000, 1'b1, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b1, 1'b0); tick(); exp_ret++;
      vec("slti", 7'b0010011, 3'b010, 1'b0, 1'b0, 2'b00, 2'b00, 3'b100, 2'b00, 1'b1, 1'b1, 1'b0); tick(); exp_ret++;
      vec("lw",   7'b0000011, 3'b010, 1'b0, 1'b0, 2'b01, 2'b00, 3'b000, 2'b00, 1'b1, 1'b1, 1'b0); tick(); exp_ret++;
      vec("jal",  7'b1101111, 3'b000, 1'b0, 1'b0, 2'b10, 2'b01, 3'b000, 2'b11, 1'b0, 1'b1, 1'b0); tick(); exp_ret++;
      vec("jalr", 7'b1100111, 3'b000, 1'b0, 1'b0, 2'b10, 2'b10, 3'b000, 2'b00, 1'b1, 1'b1, 1'b0); tick(); exp_ret++;
      vec("beq",  7'b1100011, 3'b000, 1'b0, 1'b1, 2'b00, 2'b01, 3'b001, 2'b10, 1'b0, 1'b0, 1'b0); tick(); exp_ret++;
      vec("bne",  7'b1100011, 3'b001, 1'b0, 1'b1, 2'b00, 2'b00, 3'b001, 2'b10, 1'b0, 1'b0, 1'b0); tick(); exp_ret++;
      chk("table.ret", o_retired, 32'(exp_ret));
      i_zero = 1'b0;

      // ebreak halts before executing; resume re-runs it once as a NOP.
      i_opcode = 7'b1110011; i_f3 = 3'b000;
      #1 chk("ebrk.en", 32'(o_clk_enable), 0);
      tick();
      chk("ebrk.halted", 32'(o_halted), 1);
      chk("ebrk.cause", 32'(o_halt_cause), 2);
      chk("ebrk.ret", o_retired, 32'(exp_ret));
      i_resume = 1'b1;
      tick();
      i_resume = 1'b0;
      #1 chk("nop.en", 32'(o_clk_enable), 1);
      chk("nop.halted", 32'(o_halted), 0);
      chk("nop.cause", 32'(o_halt_cause), 0);
      chk("nop.rw", 32'(o_reg_wr), 0);
      tick();
      i_opcode = 7'b0010011;
      #1 chk("nop.ret", o_retired, 32'(exp_ret));
      chk("post_nop.en", 32'(o_clk_enable), 1);
      tick(); exp_ret++;
      chk("post_nop.ret", o_retired, 32'(exp_ret));

      // Illegal opcode: sticky halt, step and resume ignored.
      i_opcode = 7'h7F;
      #1 chk("ill.en", 32'(o_clk_enable), 0);
      tick();
      chk("ill.halted", 32'(o_halted), 1);
      chk("ill.cause", 32'(o_halt_cause), 3);
      i_step = 1'b1; tick(); i_step = 1'b0;
      chk("ill.step.halted", 32'(o_halted), 1);
      chk("ill.step.en", 32'(o_clk_enable), 0);
      i_resume = 1'b1; tick(); i_resume = 1'b0;
      chk("ill.res.halted", 32'(o_halted), 1);
      chk("ill.res.cause", 32'(o_halt_cause), 3);
      chk("ill.ret", o_retired, 32'(exp_ret));

      // Reset with run_en low, then single-step two stores.
      i_run_en = 1'b0; i_opcode = 7'b0100011; i_f3 = 3'b010;
      i_rst = 1'b1;
      #1 chk("rst2.ret", o_retired, 0);
      chk("rst2.halted", 32'(o_halted), 0);
      i_rst = 1'b0; exp_ret = 0;
      tick();
      chk("hold.en", 32'(o_clk_enable), 0);
      chk("hold.mw", 32'(o_mem_wr), 0);
      tick();
      chk("runen.halted", 32'(o_halted), 1);
      chk("runen.cause", 32'(o_halt_cause), 1);
      chk("runen.mw", 32'(o_mem_wr), 0);
      for (int s = 0; s < 2; s++) begin
         i_step = 1'b1; tick(); i_step = 1'b0;
         vec("sw.step", 7'b0100011, 3'b010, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 2'b01, 1'b1, 1'b0, 1'b1);
         tick(); exp_ret++;
         chk("step.halted", 32'(o_halted), 1);
         chk("step.cause", 32'(o_halt_cause), 1);
         chk("step.en", 32'(o_clk_enable), 0);
         chk("step.mw", 32'(o_mem_wr), 0);
         chk("step.ret", o_retired, 32'(exp_ret));
      end

      // Step and resume together with run_en high: resume wins.
      i_run_en = 1'b1; i_step = 1'b1; i_resume = 1'b1;
      tick();
      i_step = 1'b0; i_resume = 1'b0;
      #1 chk("both.halted", 32'(o_halted), 0);
      chk("both.cause", 32'(o_halt_cause), 0);
      chk("both.en", 32'(o_clk_enable), 1);
      tick(); exp_ret++;
      chk("both.ret", o_retired, 32'(exp_ret));
      chk("both.mw", 32'(o_mem_wr), 1);
      // Reset mid-RUN acts immediately.
      #2 i_rst = 1'b1;
      #1 chk("midrst.en", 32'(o_clk_enable), 0);
      chk("midrst.ret", o_retired, 0);
      chk("midrst.mw", 32'(o_mem_wr), 0);
      i_rst = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
